// File: rtl/register_file_write_decoder.sv
// Write side of the general-register file: address decode, storage and zero-sweep FSM.
// Optional build macro GR0_HARDWIRE_EN makes register 0 a constant zero.
module register_file_write_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           clr_req_i,
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    output logic                           wr_ack_o,
    output logic                           wr_err_o,
    output logic [NUM_REGS-1:0]            dec_en_o,
    output logic                           clearing_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o
);

    // state    | meaning
    // ST_CLEAR | sweeping zeros into reg[cnt], one register per cycle
    // ST_IDLE  | storage valid, writes accepted unless clr_req is high

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

`ifdef GR0_HARDWIRE_EN
    localparam bit HW_GR0 = 1'b1;
`else
    localparam bit HW_GR0 = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [NUM_REGS-1:0]   WR_MASK  = HW_GR0 ? ~NUM_REGS'(1) : '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic [NUM_REGS-1:0]     addr_hit;
    logic                    addr_in_range;
    logic [NUM_REGS-1:0]     clr_en;
    logic                    accept;

    // Address decode is independent of state so dec_en stays zero-latency.
    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_hit[i] = (wr_addr_i == ADDR_WIDTH'(i));
        end
    end

    assign addr_in_range = |addr_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = accept;
        err_d   = accept && !addr_in_range;
        unique case (state_q)
            ST_CLEAR: begin
                if (clr_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clearing_o = (state_q == ST_CLEAR);
        wr_ready_o = (state_q == ST_IDLE) && !clr_req_i;
        accept     = wr_valid_i && wr_ready_o;
        dec_en_o   = accept ? (addr_hit & WR_MASK) : '0;
        clr_en     = '0;
        if (state_q == ST_CLEAR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                clr_en[i] = (cnt_q == ADDR_WIDTH'(i));
            end
        end
    end

    assign wr_ack_o = ack_q;
    assign wr_err_o = err_q;

    // Storage carries no reset; the sweep is what establishes known contents.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (HW_GR0 && (g == 0)) begin : g_zero
            assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_flop
            logic [DATA_WIDTH-1:0] data_q;
            always_ff @(posedge clk_i) begin
                if (clr_en[g]) begin
                    data_q <= '0;
                end else if (dec_en_o[g]) begin
                    data_q <= wr_data_i;
                end
            end
            assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = data_q;
        end
    end

endmodule

// File: tb/tb_register_file_write_decoder.sv
// Randomized self-checking bench for register_file_write_decoder against a behavioural model.
// A second, 20-register instance exercises out-of-range addresses.
module tb_register_file_write_decoder;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 32;
    localparam int NR2 = 20;
`ifdef GR0_HARDWIRE_EN
    localparam bit HW = 1'b1;
`else
    localparam bit HW = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              clr_req, wr_valid, wr_ready, wr_ack, wr_err, clearing;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NR-1:0]     dec_en;
    logic [NR*DW-1:0]  reg_q;

    logic              c2_clr, c2_valid, c2_ready, c2_ack, c2_err, c2_clearing;
    logic [AW-1:0]     c2_addr;
    logic [DW-1:0]     c2_data;
    logic [NR2-1:0]    c2_dec;
    logic [NR2*DW-1:0] c2_reg_q;

    register_file_write_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_req_i(clr_req), .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_ack_o(wr_ack), .wr_err_o(wr_err), .dec_en_o(dec_en),
        .clearing_o(clearing), .reg_q_o(reg_q)
    );

    register_file_write_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_req_i(c2_clr), .wr_valid_i(c2_valid),
        .wr_ready_o(c2_ready), .wr_addr_i(c2_addr), .wr_data_i(c2_data),
        .wr_ack_o(c2_ack), .wr_err_o(c2_err), .dec_en_o(c2_dec),
        .clearing_o(c2_clearing), .reg_q_o(c2_reg_q)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: register contents plus cycles left in the current sweep.
    logic [DW-1:0] m_regs [NR];
    int            m_sweep;
    bit            m_ack;

    function automatic bit writable(input int a);
        return !(HW && a == 0);
    endfunction

    task automatic model_zero();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic cycle(input bit clr, input bit valid, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, output bit accepted);
        bit            exp_ready;
        bit            exp_acc;
        logic [NR-1:0] exp_dec;
        clr_req  = clr;
        wr_valid = valid;
        wr_addr  = addr;
        wr_data  = data;
        #1;
        exp_ready = (m_sweep == 0) && !clr;
        exp_acc   = valid && exp_ready;
        exp_dec   = (exp_acc && writable(int'(addr))) ? (NR'(1) << addr) : '0;
        check_eq("wr_ready", wr_ready, exp_ready);
        check_eq("clearing", clearing, m_sweep > 0);
        check_eq("dec_en", dec_en, exp_dec);
        @(posedge clk);
        if (exp_acc && writable(int'(addr))) m_regs[addr] = data;
        m_ack = exp_acc;
        if (clr) begin
            m_sweep = NR;
            model_zero();
        end else if (m_sweep > 0) begin
            m_sweep--;
        end
        #1;
        check_eq("wr_ack", wr_ack, m_ack);
        check_eq("wr_err", wr_err, 1'b0);
        if (m_sweep == 0) begin
            for (int i = 0; i < NR; i++)
                check_eq($sformatf("reg%0d", i), reg_q[i*DW +: DW], m_regs[i]);
        end
        accepted = exp_acc;
    endtask

    task automatic do_reset(input int hold);
        rst_n    = 1'b0;
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        m_sweep  = NR;
        m_ack    = 1'b0;
        model_zero();
        #1;
        check_eq("rst_clearing", clearing, 1'b1);
        check_eq("rst_ready", wr_ready, 1'b0);
        check_eq("rst_ack", wr_ack, 1'b0);
        check_eq("rst_err", wr_err, 1'b0);
        check_eq("rst_dec_en", dec_en, '0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic count_sweep(input string tag);
        int n;
        bit acc;
        n = 0;
        while (clearing && n < 40) begin
            n++;
            cycle(1'b0, 1'b0, '0, '0, acc);
        end
        check_eq(tag, n, 32);
    endtask

    initial begin
        bit            acc;
        bit            pend;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        logic [DW-1:0] m2 [NR2];
        int            n;

        c2_clr = 1'b0; c2_valid = 1'b0; c2_addr = '0; c2_data = '0;
        wr_addr = '0; wr_data = '0;
        @(posedge clk);
        #1;

        // Reset, sweep length and cleared storage
        do_reset(3);
        count_sweep("t1_sweep_len");
        for (int i = 0; i < NR; i++)
            check_eq($sformatf("t1_zero%0d", i), reg_q[i*DW +: DW], 32'h0);

        // Single write
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, acc);
        check_eq("t2_reg5", reg_q[5*DW +: DW], 32'hDEADBEEF);
        check_eq("t2_ack", wr_ack, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, acc);

        // Back-to-back writes
        cycle(1'b0, 1'b1, 5'd1, 32'd11, acc);
        cycle(1'b0, 1'b1, 5'd2, 32'd22, acc);
        cycle(1'b0, 1'b1, 5'd31, 32'd33, acc);
        check_eq("t3_ack3", wr_ack, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, acc);
        check_eq("t3_reg1", reg_q[1*DW +: DW], 32'd11);
        check_eq("t3_reg2", reg_q[2*DW +: DW], 32'd22);
        check_eq("t3_reg31", reg_q[31*DW +: DW], 32'd33);

        // Clear request beats a simultaneous write; write lands after the sweep
        cycle(1'b0, 1'b1, 5'd7, 32'h1234, acc);
        cycle(1'b1, 1'b1, 5'd7, 32'd77, acc);
        n = 0;
        while (clearing && n < 40) begin
            n++;
            cycle(1'b0, 1'b1, 5'd7, 32'd77, acc);
            check_eq("t4_early_accept", acc, 1'b0);
        end
        check_eq("t4_sweep_len", n, 32);
        check_eq("t4_reg7_cleared", reg_q[7*DW +: DW], 32'h0);
        cycle(1'b0, 1'b1, 5'd7, 32'd77, acc);
        check_eq("t4_reg7", reg_q[7*DW +: DW], 32'd77);
        cycle(1'b0, 1'b0, '0, '0, acc);

        // Reset in the middle of a sweep
        cycle(1'b1, 1'b0, '0, '0, acc);
        repeat (10) cycle(1'b0, 1'b0, '0, '0, acc);
        do_reset(2);
        count_sweep("t5_sweep_len");

        // Register 0
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, acc);
        check_eq("t6_ack", wr_ack, 1'b1);
        check_eq("t6_reg0", reg_q[0 +: DW], HW ? 32'h0 : 32'hFFFF_FFFF);

        // Random traffic with occasional clear requests
        pend = 1'b0; p_addr = '0; p_data = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend   = 1'b1;
                p_addr = AW'($urandom_range(0, NR - 1));
                p_data = $urandom;
            end
            cycle($urandom_range(0, 49) == 0, pend, p_addr, p_data, acc);
            if (acc) pend = 1'b0;
        end
        cycle(1'b0, 1'b0, '0, '0, acc);

        // Out-of-range addresses on the 20-register instance
        for (int i = 0; i < NR2; i++) m2[i] = '0;
        check_eq("c2_idle", c2_clearing, 1'b0);
        c2_valid = 1'b1; c2_addr = 5'd19; c2_data = 32'hA5A5_5A5A;
        #1;
        check_eq("c2_ready", c2_ready, 1'b1);
        check_eq("c2_dec19", c2_dec, NR2'(1) << 19);
        @(posedge clk); #1;
        m2[19] = 32'hA5A5_5A5A;
        check_eq("c2_ack19", c2_ack, 1'b1);
        check_eq("c2_err19", c2_err, 1'b0);
        c2_addr = 5'd25; c2_data = 32'h0BAD_F00D;
        #1;
        check_eq("c2_dec25", c2_dec, '0);
        @(posedge clk); #1;
        check_eq("c2_ack25", c2_ack, 1'b1);
        check_eq("c2_err25", c2_err, 1'b1);
        c2_addr = 5'd20;
        @(posedge clk); #1;
        check_eq("c2_err20", c2_err, 1'b1);
        c2_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("c2_ack_end", c2_ack, 1'b0);
        check_eq("c2_err_end", c2_err, 1'b0);
        for (int i = 0; i < NR2; i++)
            check_eq($sformatf("c2_reg%0d", i), c2_reg_q[i*DW +: DW], m2[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
